dspb_serum_pio_debounce: RTL and testbench
==========================================

DSPB_SERUM_PIO_DEBOUNCE -- requirements
Module: dspb_serum_pio_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of input bits conditioned.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, stable cycles required before output change, minimum 2.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 raw_in  input  WIDTH  asynchronous board inputs (switches, status lines).
REQ-007 db_out  output  WIDTH  debounced level, drives downstream PIO in_port.
REQ-008 address  input  2  Avalon-MM slave word address.
REQ-009 write  input  1  Avalon-MM write strobe.
REQ-010 writedata  input  32  Avalon-MM write data.
REQ-011 readdata  output  32  Avalon-MM read data, registered, zero-extended.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 Each raw_in bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-014 Per bit, while the synchronized value equals db_out, the bit's counter SHALL hold 0.
REQ-015 Per bit, while the synchronized value differs from db_out, the counter SHALL increment once per cycle.
REQ-016 When the counter equals DEBOUNCE_CYCLES-1 and the value still differs, db_out SHALL take the synchronized value on that edge and the counter SHALL return to 0.
REQ-017 Any return to agreement before terminal count SHALL clear the counter; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach db_out.
REQ-018 Latency from a clean raw_in step to db_out change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap.
REQ-020 Register map: offset 0 db_out (RO), offset 1 edge_cap (RO, write-1-to-clear), offset 2 irq_mask (RW, bits WIDTH-1:0), offset 3 reads 0, writes ignored.
REQ-021 edge_cap[i] SHALL set on the edge where db_out[i] changes in either direction.
REQ-022 Simultaneous set and W1C of the same edge_cap bit SHALL leave the bit set.
REQ-023 readdata SHALL update every cycle with the addressed register, zero-extended, one cycle after address is presented (no read strobe).
REQ-024 irq SHALL equal |(edge_cap & irq_mask), decoded from registers only, no combinational path from bus inputs.
REQ-025 Writedata bits above WIDTH-1 SHALL be ignored.

Reset
REQ-026 On reset_n low: synchronizer flops, counters, db_out, edge_cap, irq_mask, readdata SHALL all be 0; irq SHALL be 0.
REQ-027 Reset asserted mid-debounce SHALL discard the count; counting restarts from 0 after release.
REQ-028 An input already high at reset release SHALL propagate to db_out after the REQ-018 latency and SHALL set edge_cap.

Structure
REQ-029 Shared package dspb_serum_pio_pkg SHALL hold register offset constants (OFS_DATA, OFS_EDGE, OFS_MASK) and default parameter values.
REQ-030 Per-bit synchronizer plus counter SHALL be sub-module dspb_serum_debounce_bit, instantiated WIDTH times by generate loop; register file and irq reside in top.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 raw_in 0x00->0x01 held -> db_out=0x01 exactly 6 edges later; offset 1 reads 0x01.
REQ-032 raw_in[3] high for 3 cycles then low -> db_out stays 0x00, edge_cap stays 0x00.
REQ-033 edge_cap=0x05, write 0x04 to offset 1 -> next read of offset 1 returns 0x01.
REQ-034 W1C of bit 0 on same edge db_out[0] toggles -> edge_cap[0] remains 1.
REQ-035 irq_mask=0x02, db_out[1] rises -> irq=1 on the edge after edge_cap[1] sets; write 0x00 to offset 2 -> irq=0 next cycle.
REQ-036 reset_n pulsed low at count 2 of a pending change -> all outputs 0; change appears 6 edges after release if raw_in still held.

Source files
------------

// File: rtl/dspb_serum_pio_pkg.sv
// Shared constants for the debounced PIO block: register offsets and
// default parameter values.
package dspb_serum_pio_pkg;

  localparam int DEF_WIDTH           = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;

  localparam logic [1:0] OFS_DATA = 2'd0;  // debounced level, RO
  localparam logic [1:0] OFS_EDGE = 2'd1;  // edge capture, RO / W1C
  localparam logic [1:0] OFS_MASK = 2'd2;  // irq mask, RW
  localparam logic [1:0] OFS_RSVD = 2'd3;  // reads 0, writes ignored

endpackage

// File: rtl/dspb_serum_debounce_bit.sv
// One input bit: synchronizer chain followed by a stable-count debouncer.
// o_fire pulses on the cycle whose edge will flip o_db.
module dspb_serum_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_db,
  output logic o_fire
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_db;
  logic                   w_sync;
  logic                   w_diff;
  logic                   w_fire;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_db;
  // Terminal count is DEBOUNCE_CYCLES-1, so the counter never needs to wrap.
  assign w_fire = w_diff && (r_cnt == CNT_TERM);

  // Synchronizer shift chain; nothing else looks at i_raw.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  // Count cycles of disagreement; any agreement or a fire restarts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_cnt <= '0;
    else if (!w_diff || w_fire) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

  // Debounced level follows the synchronized value only at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_db <= 1'b0;
    else if (w_fire) r_db <= w_sync;
  end

  assign o_db   = r_db;
  assign o_fire = w_fire;

endmodule

// File: rtl/dspb_serum_pio_debounce.sv
// Debounced PIO input conditioner with a small Avalon-MM register file:
// level, edge capture (W1C), irq mask and a registered level interrupt.
// WIDTH is expected to be at most 32.
module dspb_serum_pio_debounce
  import dspb_serum_pio_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_fire;
  logic [WIDTH-1:0] w_edge_clr;
  logic [31:0]      w_rd;
  logic             w_unused_wdata;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_rdata;
  logic             r_irq;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dspb_serum_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .i_raw  (raw_in[g]),
      .o_db   (w_db[g]),
      .o_fire (w_fire[g])
    );
  end

  // Bits above WIDTH-1 carry no meaning on writes.
  assign w_unused_wdata = ^writedata;

  assign w_edge_clr = (write && address == OFS_EDGE) ? writedata[WIDTH-1:0] : '0;

  // Edge capture: a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge <= '0;
    else          r_edge <= (r_edge & ~w_edge_clr) | w_fire;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_mask <= '0;
    else if (write && address == OFS_MASK) r_mask <= writedata[WIDTH-1:0];
  end

  // Read mux for the addressed register, zero-extended.
  always_comb begin
    w_rd = '0;
    case (address)
      OFS_DATA: w_rd = 32'(w_db);
      OFS_EDGE: w_rd = 32'(r_edge);
      OFS_MASK: w_rd = 32'(r_mask);
      default:  w_rd = '0;
    endcase
  end

  // Registered read data and interrupt; irq sees only register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rdata <= w_rd;
      r_irq   <= |(r_edge & r_mask);
    end
  end

  assign db_out   = w_db;
  assign readdata = r_rdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_dspb_serum_pio_debounce.sv
// Scenario bench for the debounced PIO (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_dspb_serum_pio_debounce;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] db_out;
  logic [1:0]   address = '0;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         irq;

  int n_run = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  dspb_serum_pio_debounce #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .db_out(db_out),
    .address(address), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
  endtask

  // Expected value queued when the address is driven, compared when data returns.
  task automatic do_read(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    address = a; write = 1'b0;
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    n_run++;
    if (readdata !== e) begin
      n_fail++;
      $display("FAIL %s: readdata=%h expected=%h", nm, readdata, e);
    end
  endtask

  task automatic chk_db(input string nm, input logic [W-1:0] exp);
    n_run++;
    if (db_out !== exp) begin
      n_fail++;
      $display("FAIL %s: db_out=%h expected=%h", nm, db_out, exp);
    end
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    n_run++;
    if (irq !== exp) begin
      n_fail++;
      $display("FAIL %s: irq=%b expected=%b", nm, irq, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    chk_db("reset_db", 8'h00);
    chk_irq("reset_irq", 1'b0);
    n_run++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: readdata=%h expected=%h", readdata, 32'h0);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_glitch();
    raw_in = 8'h08;
    tick(3);
    raw_in = 8'h00;
    tick(10);
    chk_db("glitch_db", 8'h00);
    do_read("glitch_edge", 2'd1, 32'h0);
  endtask

  task automatic test_latency();
    raw_in = 8'h01;
    tick(5);
    chk_db("lat_before", 8'h00);
    tick();
    chk_db("lat_at6", 8'h01);
    do_read("lat_edge", 2'd1, 32'h1);
    do_read("lat_data", 2'd0, 32'h1);
  endtask

  task automatic test_w1c();
    raw_in = 8'h05;
    tick(8);
    chk_db("w1c_db", 8'h05);
    do_read("w1c_pre", 2'd1, 32'h5);
    do_write(2'd1, 32'h4);
    do_read("w1c_post", 2'd1, 32'h1);
    do_write(2'd2, 32'hFFFF_FF02);
    do_read("mask_upper", 2'd2, 32'h2);
    do_write(2'd2, 32'h0);
    do_write(2'd1, 32'hFF);
    do_read("w1c_all", 2'd1, 32'h0);
  endtask

  task automatic test_w1c_collision();
    raw_in = 8'h04;
    tick(5);
    address = 2'd1; writedata = 32'h1; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
    chk_db("coll_db", 8'h04);
    do_read("coll_edge", 2'd1, 32'h1);
    do_write(2'd1, 32'h1);
    do_read("coll_clr", 2'd1, 32'h0);
  endtask

  task automatic test_irq();
    do_write(2'd2, 32'h2);
    raw_in = 8'h06;
    tick(6);
    chk_db("irq_db", 8'h06);
    chk_irq("irq_lag", 1'b0);
    tick();
    chk_irq("irq_set", 1'b1);
    do_write(2'd2, 32'h0);
    tick();
    chk_irq("irq_masked", 1'b0);
    tick(3);
    chk_irq("irq_hold0", 1'b0);
  endtask

  task automatic test_reset_mid();
    raw_in = 8'h16;
    tick(4);
    reset_n = 1'b0;
    #1;
    chk_db("rst_db", 8'h00);
    chk_irq("rst_irq", 1'b0);
    n_run++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: readdata=%h expected=%h", readdata, 32'h0);
    end
    tick();
    reset_n = 1'b1;
    tick(5);
    chk_db("rst_before", 8'h00);
    tick();
    chk_db("rst_at6", 8'h16);
  endtask

  task automatic test_back_to_back();
    do_write(2'd3, 32'hFF);
    do_write(2'd2, 32'h10);
    do_read("b2b_data", 2'd0, 32'h16);
    do_read("b2b_edge", 2'd1, 32'h16);
    do_read("b2b_mask", 2'd2, 32'h10);
    do_read("b2b_rsvd", 2'd3, 32'h0);
    chk_irq("b2b_irq", 1'b1);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_w1c();
    test_w1c_collision();
    test_irq();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
